// File: rtl/mux_lp_pwr_sched_pkg.sv
// Shared encodings for the pulsed-power mux scheduler.
// FSM states, round-robin pointer values and a sizing helper.
package mux_lp_pwr_sched_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_CAPT  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mux_lp_rr_arb.sv
// Two-way round-robin arbiter for the mux scheduler.
// The pointer moves to the side that did not own the last access.
module mux_lp_rr_arb
    import mux_lp_pwr_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    input  logic owner_a,
    output logic win_a,
    output logic win_b
);

    logic ptr;

    assign win_a = req_a & (~req_b | (ptr == PTR_A));
    assign win_b = req_b & ~win_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PTR_A;
        end else if (advance) begin
            ptr <= owner_a ? PTR_B : PTR_A;
        end
    end

endmodule

// File: rtl/mux_lp_pwr_sched.sv
// Shares a pulsed-power 2:1 mux between two requesters and
// sequences setup, supply pulse, capture and cooldown.
module mux_lp_pwr_sched
    import mux_lp_pwr_sched_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic din_a,
    input  logic req_b,
    input  logic din_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic done_a,
    output logic done_b,
    output logic dout,
    output logic busy,
    output logic mux_a,
    output logic mux_b,
    output logic mux_sel,
    output logic pwr_clk,
    input  logic mux_y
);

    localparam int CW =
        $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          win_a;
    logic          win_b;
    logic          any_req;
    logic          last;
    logic          grant;

    assign any_req = req_a | req_b;
    assign last    = (cnt == CW'(1));
    assign grant   = (state == ST_IDLE) & any_req;

    mux_lp_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .advance (state == ST_CAPT),
        .owner_a (gnt_a),
        .win_a   (win_a),
        .win_b   (win_b)
    );

    // Counter is loaded on entry; each timed state exits at count==1.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nx = ST_SETUP;
                    cnt_nx   = CW'(SETUP_CYC);
                end
            end
            ST_SETUP: begin
                if (last) begin
                    state_nx = ST_PULSE;
                    cnt_nx   = CW'(PULSE_CYC);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_PULSE: begin
                if (last) begin
                    state_nx = ST_CAPT;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_CAPT: begin
                if (GAP_CYC > 0) begin
                    state_nx = ST_GAP;
                    cnt_nx   = CW'(GAP_CYC);
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (last) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            dout    <= 1'b0;
            busy    <= 1'b0;
            mux_a   <= 1'b0;
            mux_b   <= 1'b0;
            mux_sel <= 1'b0;
            pwr_clk <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            busy    <= (state_nx != ST_IDLE);
            pwr_clk <= (state_nx == ST_PULSE);
            done_a  <= (state_nx == ST_CAPT) & gnt_a;
            done_b  <= (state_nx == ST_CAPT) & gnt_b;
            // Mux drive is frozen from grant through capture.
            if (grant) begin
                gnt_a   <= win_a;
                gnt_b   <= win_b;
                mux_sel <= win_a;
                mux_a   <= win_a & din_a;
                mux_b   <= win_b & din_b;
            end else if (state == ST_CAPT) begin
                gnt_a   <= 1'b0;
                gnt_b   <= 1'b0;
                mux_sel <= 1'b0;
                mux_a   <= 1'b0;
                mux_b   <= 1'b0;
            end
            if ((state == ST_PULSE) && last) begin
                dout <= mux_y;
            end
        end
    end

endmodule

// File: tb/tb_mux_lp_pwr_sched.sv
// Bench for mux_lp_pwr_sched: two configurations, a timeline
// model of each access, plus hand-computed latency and order checks.
module tb_mux_lp_pwr_sched;

    localparam int S0 = 1;
    localparam int P0 = 2;
    localparam int G0 = 1;
    localparam int S1 = 3;
    localparam int P1 = 1;
    localparam int G1 = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ra, rb, da, db;
    logic [1:0] gnt_a, gnt_b, done_a, done_b;
    logic [1:0] dout, busy, mux_a, mux_b;
    logic [1:0] mux_sel, pwr_clk, mux_y;

    int vectors = 0;
    int errs    = 0;
    bit cmp_en  = 0;

    always #5 clk = ~clk;

    // Behavioural pulsed-power mux: output only while supplied.
    for (genvar k = 0; k < 2; k++) begin : g_mux
        assign mux_y[k] = pwr_clk[k] ?
            (mux_sel[k] ? mux_a[k] : mux_b[k]) : 1'b0;
    end

    mux_lp_pwr_sched #(
        .SETUP_CYC(S0), .PULSE_CYC(P0), .GAP_CYC(G0)
    ) u0 (
        .clk(clk), .rst(rst),
        .req_a(ra[0]), .din_a(da[0]),
        .req_b(rb[0]), .din_b(db[0]),
        .gnt_a(gnt_a[0]), .gnt_b(gnt_b[0]),
        .done_a(done_a[0]), .done_b(done_b[0]),
        .dout(dout[0]), .busy(busy[0]),
        .mux_a(mux_a[0]), .mux_b(mux_b[0]),
        .mux_sel(mux_sel[0]), .pwr_clk(pwr_clk[0]),
        .mux_y(mux_y[0])
    );

    mux_lp_pwr_sched #(
        .SETUP_CYC(S1), .PULSE_CYC(P1), .GAP_CYC(G1)
    ) u1 (
        .clk(clk), .rst(rst),
        .req_a(ra[1]), .din_a(da[1]),
        .req_b(rb[1]), .din_b(db[1]),
        .gnt_a(gnt_a[1]), .gnt_b(gnt_b[1]),
        .done_a(done_a[1]), .done_b(done_b[1]),
        .dout(dout[1]), .busy(busy[1]),
        .mux_a(mux_a[1]), .mux_b(mux_b[1]),
        .mux_sel(mux_sel[1]), .pwr_clk(pwr_clk[1]),
        .mux_y(mux_y[1])
    );

    function automatic int sc(int k);
        return (k == 0) ? S0 : S1;
    endfunction
    function automatic int pc(int k);
        return (k == 0) ? P0 : P1;
    endfunction
    function automatic int gc(int k);
        return (k == 0) ? G0 : G1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Access model: one timeline per access, measured from its grant.
    int cyc = 0;
    bit act[2];
    int t0[2];
    bit own_a[2];
    bit ptr_a[2];
    bit din_m[2];
    bit dout_m[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                act[k]    = 0;
                ptr_a[k]  = 1;
                dout_m[k] = 0;
            end else if (act[k]) begin
                int rel;
                rel = cyc - t0[k];
                if (rel == sc(k) + pc(k) - 1) dout_m[k] = din_m[k];
                if (rel == sc(k) + pc(k)) ptr_a[k] = !own_a[k];
                if (rel == sc(k) + pc(k) + gc(k)) act[k] = 0;
            end else if (ra[k] || rb[k]) begin
                own_a[k] = ra[k] && (!rb[k] || ptr_a[k]);
                din_m[k] = own_a[k] ? da[k] : db[k];
                t0[k]    = cyc + 1;
                act[k]   = 1;
            end
        end
        cyc++;
    end

    // {gnt_a,gnt_b,done_a,done_b,dout,busy,mux_a,mux_b,mux_sel,pwr}
    function automatic logic [9:0] expv(int k);
        logic [9:0] v;
        int rel;
        bit own, pw, dn;
        v    = '0;
        v[5] = dout_m[k];
        if (act[k]) begin
            rel  = cyc - t0[k];
            own  = rel <= sc(k) + pc(k);
            pw   = rel >= sc(k) && rel < sc(k) + pc(k);
            dn   = rel == sc(k) + pc(k);
            v[9] = own && own_a[k];
            v[8] = own && !own_a[k];
            v[7] = dn && own_a[k];
            v[6] = dn && !own_a[k];
            v[4] = 1'b1;
            v[3] = own && own_a[k] && din_m[k];
            v[2] = own && !own_a[k] && din_m[k];
            v[1] = own && own_a[k];
            v[0] = pw;
        end
        return v;
    endfunction

    function automatic logic [9:0] dutv(int k);
        return {gnt_a[k], gnt_b[k], done_a[k], done_b[k], dout[k],
                busy[k], mux_a[k], mux_b[k], mux_sel[k], pwr_clk[k]};
    endfunction

    logic [2:0] drv_prev[2];
    logic       pwr_prev[2];

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("outs%0d", k), 32'(dutv(k)), 32'(expv(k)));
                chk($sformatf("gnt_excl%0d", k),
                    32'(gnt_a[k] & gnt_b[k]), 32'd0);
                if (pwr_clk[k] && pwr_prev[k])
                    chk($sformatf("frozen%0d", k),
                        32'({mux_sel[k], mux_a[k], mux_b[k]}),
                        32'(drv_prev[k]));
                if (done_a[k] || done_b[k])
                    chk($sformatf("done_gnt%0d", k),
                        32'({gnt_a[k], gnt_b[k]}),
                        32'({done_a[k], done_b[k]}));
            end
        end
        for (int k = 0; k < 2; k++) begin
            drv_prev[k] = {mux_sel[k], mux_a[k], mux_b[k]};
            pwr_prev[k] = pwr_clk[k];
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(int k, bit side_a, int lat, string nm);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 30) begin
            step(1);
            n++;
            seen = side_a ? done_a[k] : done_b[k];
        end
        chk(nm, 32'(n), 32'(lat));
    endtask

    task automatic collect(int k, int cnt, int pitch, bit first_a,
                           string nm);
        int n, got, last;
        bit exp_a;
        n     = 0;
        got   = 0;
        last  = -1;
        exp_a = first_a;
        while (got < cnt && n < 60) begin
            step(1);
            n++;
            if (done_a[k] || done_b[k]) begin
                chk({nm, "_who"}, 32'(done_a[k]), 32'(exp_a));
                if (last >= 0)
                    chk({nm, "_pitch"}, 32'(n - last), 32'(pitch));
                last  = n;
                got++;
                exp_a = !exp_a;
            end
        end
        chk({nm, "_cnt"}, 32'(got), 32'(cnt));
    endtask

    initial begin
        rst = 1'b1;
        ra  = '0;
        rb  = '0;
        da  = '0;
        db  = '0;
        step(2);
        cmp_en = 1;
        chk("rst_outs0", 32'(dutv(0)), 32'd0);
        chk("rst_outs1", 32'(dutv(1)), 32'd0);
        rst = 1'b0;
        step(1);

        // Single A on defaults, cycle-by-cycle.
        ra[0] = 1'b1;
        da[0] = 1'b1;
        step(1);
        chk("a_c1_gnt", 32'({gnt_a[0], pwr_clk[0]}), 32'b10);
        step(1);
        chk("a_c2_pwr", 32'({pwr_clk[0], mux_sel[0]}), 32'b11);
        step(1);
        chk("a_c3_pwr", 32'(pwr_clk[0]), 32'd1);
        step(1);
        chk("a_c4_done", 32'({done_a[0], dout[0], pwr_clk[0]}),
            32'b110);
        ra[0] = 1'b0;
        step(3);

        // Single B with a 0 data bit: dout must fall from 1.
        rb[0] = 1'b1;
        db[0] = 1'b0;
        wait_done(0, 1'b0, 4, "b_latency");
        chk("b_dout", 32'(dout[0]), 32'd0);
        rb[0] = 1'b0;
        step(3);

        // Contention on defaults: A,B,A,B six cycles apart.
        ra[0] = 1'b1;
        rb[0] = 1'b1;
        da[0] = 1'b1;
        db[0] = 1'b0;
        collect(0, 4, 6, 1'b1, "cont0");
        ra[0] = 1'b0;
        rb[0] = 1'b0;
        step(3);

        // Long setup, single-cycle pulse, no cooldown.
        ra[1] = 1'b1;
        da[1] = 1'b1;
        wait_done(1, 1'b1, 5, "sweep_latency");
        chk("sweep_dout", 32'(dout[1]), 32'd1);
        ra[1] = 1'b0;
        step(2);
        ra[1] = 1'b1;
        rb[1] = 1'b1;
        da[1] = 1'b0;
        db[1] = 1'b1;
        collect(1, 4, 6, 1'b0, "cont1");
        ra[1] = 1'b0;
        rb[1] = 1'b0;
        step(3);

        // Reset in the middle of the supply pulse.
        ra[0] = 1'b1;
        da[0] = 1'b1;
        step(2);
        chk("pre_rst_pwr", 32'(pwr_clk[0]), 32'd1);
        rst = 1'b1;
        step(1);
        chk("rst_abort",
            32'({pwr_clk[0], gnt_a[0], done_a[0], busy[0]}), 32'd0);
        rst   = 1'b0;
        rb[0] = 1'b1;
        db[0] = 1'b1;
        step(1);
        chk("rst_ptr_a", 32'({gnt_a[0], gnt_b[0]}), 32'b10);
        wait_done(0, 1'b1, 3, "rst_a_done");
        ra[0] = 1'b0;
        wait_done(0, 1'b0, 6, "rst_b_done");
        chk("rst_b_dout", 32'(dout[0]), 32'd1);
        rb[0] = 1'b0;
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

endmodule
